// File: rtl/pp_reduce_pipe.sv
// Partial-product generator and Dadda compressor for an approximate 6x6 multiplier.
// Two valid/ready register stages; the final two rows feed an 11-bit carry-lookahead adder.
module pp_reduce_pipe #(
    parameter int APPROX_COLS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] row_a,
    output logic [10:0] row_b
);

    // Heap after the first Dadda level (max height 4), one field per column.
    typedef struct packed {
        logic       c10;
        logic [1:0] c9;
        logic [3:0] c8;
        logic [3:0] c7;
        logic [3:0] c6;
        logic [3:0] c5;
        logic [3:0] c4;
        logic [3:0] c3;
        logic [2:0] c2;
        logic [1:0] c1;
        logic       c0;
    } heap4_t;

    // Heap after the second Dadda level (max height 3).
    typedef struct packed {
        logic       c10;
        logic [2:0] c9;
        logic [2:0] c8;
        logic [2:0] c7;
        logic [2:0] c6;
        logic [2:0] c5;
        logic [2:0] c4;
        logic [2:0] c3;
        logic [2:0] c2;
        logic [1:0] c1;
        logic       c0;
    } heap3_t;

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {1'b0, x} + {1'b0, y} + {1'b0, z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    logic [5:0][5:0] mp_s;
    logic [10:0]     low_s;
    heap4_t          l1_s;
    logic            c5a_s, c6a_s, c6b_s, c7a_s, c7b_s, c8a_s;
    heap3_t          l2_s;
    logic [9:4]      cy2_s;
    logic [10:3]     cy3_s;
    logic [10:0]     ra_s;
    logic [10:0]     rb_s;
    logic            en1_s;
    logic            en2_s;

    logic            s1_valid_r;
    heap4_t          l1_r;
    logic [10:0]     low_r;

    assign en2_s    = ~out_valid | out_ready;
    assign en1_s    = ~s1_valid_r | en2_s;
    assign in_ready = en1_s;

    // Partial products: low columns are OR-collapsed and masked out of the exact tree.
    always_comb begin
        mp_s  = '0;
        low_s = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (i + j >= APPROX_COLS) begin
                    mp_s[i][j] = a[i] & b[j];
                end else begin
                    low_s[i+j] = low_s[i+j] | (a[i] & b[j]);
                end
            end
        end
    end

    // Dadda level 1: column heights reduced from 6 to 4.
    always_comb begin
        l1_s  = '0;
        c5a_s = 1'b0;
        c6a_s = 1'b0;
        c6b_s = 1'b0;
        c7a_s = 1'b0;
        c7b_s = 1'b0;
        c8a_s = 1'b0;
        l1_s.c0 = mp_s[0][0];
        l1_s.c1 = {mp_s[1][0], mp_s[0][1]};
        l1_s.c2 = {mp_s[2][0], mp_s[1][1], mp_s[0][2]};
        l1_s.c3 = {mp_s[3][0], mp_s[2][1], mp_s[1][2], mp_s[0][3]};
        {c5a_s, l1_s.c4[0]} = ha(mp_s[0][4], mp_s[1][3]);
        l1_s.c4[3:1] = {mp_s[4][0], mp_s[3][1], mp_s[2][2]};
        {c6a_s, l1_s.c5[0]} = fa(mp_s[0][5], mp_s[1][4], mp_s[2][3]);
        {c6b_s, l1_s.c5[1]} = ha(mp_s[3][2], mp_s[4][1]);
        l1_s.c5[3:2] = {c5a_s, mp_s[5][0]};
        {c7a_s, l1_s.c6[0]} = fa(mp_s[1][5], mp_s[2][4], mp_s[3][3]);
        {c7b_s, l1_s.c6[1]} = ha(mp_s[4][2], mp_s[5][1]);
        l1_s.c6[3:2] = {c6b_s, c6a_s};
        {c8a_s, l1_s.c7[0]} = fa(mp_s[2][5], mp_s[3][4], mp_s[4][3]);
        l1_s.c7[3:1] = {c7b_s, c7a_s, mp_s[5][2]};
        l1_s.c8 = {c8a_s, mp_s[5][3], mp_s[4][4], mp_s[3][5]};
        l1_s.c9 = {mp_s[5][4], mp_s[4][5]};
        l1_s.c10 = mp_s[5][5];
    end

    // Dadda level 2: heights 4 -> 3, operating on the stage-1 register.
    always_comb begin
        l2_s  = '0;
        cy2_s = '0;
        l2_s.c0 = l1_r.c0;
        l2_s.c1 = l1_r.c1;
        l2_s.c2 = l1_r.c2;
        {cy2_s[4], l2_s.c3[0]} = ha(l1_r.c3[0], l1_r.c3[1]);
        l2_s.c3[2:1] = l1_r.c3[3:2];
        {cy2_s[5], l2_s.c4[0]} = fa(l1_r.c4[0], l1_r.c4[1], l1_r.c4[2]);
        l2_s.c4[2:1] = {cy2_s[4], l1_r.c4[3]};
        {cy2_s[6], l2_s.c5[0]} = fa(l1_r.c5[0], l1_r.c5[1], l1_r.c5[2]);
        l2_s.c5[2:1] = {cy2_s[5], l1_r.c5[3]};
        {cy2_s[7], l2_s.c6[0]} = fa(l1_r.c6[0], l1_r.c6[1], l1_r.c6[2]);
        l2_s.c6[2:1] = {cy2_s[6], l1_r.c6[3]};
        {cy2_s[8], l2_s.c7[0]} = fa(l1_r.c7[0], l1_r.c7[1], l1_r.c7[2]);
        l2_s.c7[2:1] = {cy2_s[7], l1_r.c7[3]};
        {cy2_s[9], l2_s.c8[0]} = fa(l1_r.c8[0], l1_r.c8[1], l1_r.c8[2]);
        l2_s.c8[2:1] = {cy2_s[8], l1_r.c8[3]};
        l2_s.c9 = {cy2_s[9], l1_r.c9};
        l2_s.c10 = l1_r.c10;
    end

    // Dadda level 3: heights 3 -> 2; column 10 never carries, so both rows fit 11 bits.
    always_comb begin
        ra_s  = '0;
        rb_s  = '0;
        cy3_s = '0;
        ra_s[0] = l2_s.c0;
        ra_s[1] = l2_s.c1[0];
        rb_s[1] = l2_s.c1[1];
        {cy3_s[3], ra_s[2]} = ha(l2_s.c2[0], l2_s.c2[1]);
        rb_s[2] = l2_s.c2[2];
        {cy3_s[4], ra_s[3]} = fa(l2_s.c3[0], l2_s.c3[1], l2_s.c3[2]);
        rb_s[3] = cy3_s[3];
        {cy3_s[5], ra_s[4]} = fa(l2_s.c4[0], l2_s.c4[1], l2_s.c4[2]);
        rb_s[4] = cy3_s[4];
        {cy3_s[6], ra_s[5]} = fa(l2_s.c5[0], l2_s.c5[1], l2_s.c5[2]);
        rb_s[5] = cy3_s[5];
        {cy3_s[7], ra_s[6]} = fa(l2_s.c6[0], l2_s.c6[1], l2_s.c6[2]);
        rb_s[6] = cy3_s[6];
        {cy3_s[8], ra_s[7]} = fa(l2_s.c7[0], l2_s.c7[1], l2_s.c7[2]);
        rb_s[7] = cy3_s[7];
        {cy3_s[9], ra_s[8]} = fa(l2_s.c8[0], l2_s.c8[1], l2_s.c8[2]);
        rb_s[8] = cy3_s[8];
        {cy3_s[10], ra_s[9]} = fa(l2_s.c9[0], l2_s.c9[1], l2_s.c9[2]);
        rb_s[9] = cy3_s[9];
        ra_s[10] = l2_s.c10;
        rb_s[10] = cy3_s[10];
    end

    // Stage 1: partial-product heap after the first reduction level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            l1_r       <= '0;
            low_r      <= 11'd0;
        end else if (en1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                l1_r  <= l1_s;
                low_r <= low_s;
            end
        end
    end

    // Stage 2: final rows; the exact tree leaves low columns zero, so OR in the approximation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            row_a     <= 11'd0;
            row_b     <= 11'd0;
        end else if (en2_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                row_a <= ra_s | low_r;
                row_b <= rb_s;
            end
        end
    end

endmodule
